// File: rtl/ex_div_stallreq_pkg.sv
// Shared definitions for the EX-stage iterative divider and its stall request.
package ex_div_stallreq_pkg;

    localparam int unsigned DIV_ITER = 32;

    // Stall request levels seen by the stall controller
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_stallreq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module ex_div_stallreq_div_step
    import ex_div_stallreq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] divisor_ext;

    // Trial subtraction; the remainder always stays below the divisor so it fits WIDTH bits
    always_comb begin
        partial     = {rem_i, bit_i};
        divisor_ext = {1'b0, divisor_i};
        q_o         = (partial >= divisor_ext);
        rem_o       = q_o ? WIDTH'(partial - divisor_ext) : WIDTH'(partial);
    end

endmodule

// File: rtl/ex_div_stallreq.sv
// Iterative radix-2 restoring divider for the EX stage, driving the EX stall
// request. Optional macro DIV_BYZERO_FAST_EN short-cuts zero divisors via BYZERO.
module ex_div_stallreq
    import ex_div_stallreq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [0:WIDTH-1] dividend_i,
    input  logic [0:WIDTH-1] divisor_i,
    output logic [0:WIDTH-1] quot_o,
    output logic [0:WIDTH-1] rem_o,
    output logic             ready_o,
    output logic             stallreq_fr_ex_o
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_q;     // abs dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] raw_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;

    logic [WIDTH-1:0] dvd_in, dsr_in, dvd_abs, dsr_abs;
    logic             dvd_neg, dsr_neg, accept;
    logic [WIDTH-1:0] step_rem, uq, fin_q, fin_r;
    logic             step_q;

    // Operand conditioning and acceptance
    always_comb begin
        dvd_in  = dividend_i;
        dsr_in  = divisor_i;
        dvd_neg = signed_i & dvd_in[WIDTH-1];
        dsr_neg = signed_i & dsr_in[WIDTH-1];
        dvd_abs = dvd_neg ? -dvd_in : dvd_in;
        dsr_abs = dsr_neg ? -dsr_in : dsr_in;
        accept  = (state == IDLE) && start_i && !annul_i;
    end

    // Stall request: held through the divide, released in END or on annul
    always_comb begin
        stallreq_fr_ex_o = NOSTOP;
        if (accept || (((state == ON) || (state == BYZERO)) && !annul_i))
            stallreq_fr_ex_o = STOP;
    end

    ex_div_stallreq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Final result including sign fix-up; a zero divisor bypasses the fix-up
    always_comb begin
        uq    = {dvd_q[WIDTH-2:0], step_q};
        fin_q = neg_quo_q ? -uq : uq;
        fin_r = neg_rem_q ? -step_rem : step_rem;
        if (zero_q) begin
            fin_q = '1;
            fin_r = raw_q;
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            prem_q    <= '0;
            raw_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            quot_o    <= '0;
            rem_o     <= '0;
            ready_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_q     <= dvd_abs;
                        dsr_q     <= dsr_abs;
                        prem_q    <= '0;
                        raw_q     <= dvd_in;
                        neg_quo_q <= dvd_neg ^ dsr_neg;
                        neg_rem_q <= dvd_neg;
                        zero_q    <= (dsr_in == '0);
                        cnt       <= '0;
                        if (dsr_in == '0) begin
`ifdef DIV_BYZERO_FAST_EN
                            state <= BYZERO;
`else
                            state <= ON;
`endif
                        end else begin
                            state <= ON;
                        end
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        prem_q <= step_rem;
                        dvd_q  <= {dvd_q[WIDTH-2:0], step_q};
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state   <= END;
                            quot_o  <= fin_q;
                            rem_o   <= fin_r;
                            ready_o <= 1'b1;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state   <= END;
                        quot_o  <= fin_q;
                        rem_o   <= fin_r;
                        ready_o <= 1'b1;
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_stallreq.sv
// Directed self-checking bench for ex_div_stallreq (honours DIV_BYZERO_FAST_EN).
module tb_ex_div_stallreq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [31:0] quot_o;
    logic [31:0] rem_o;
    logic        ready_o;
    logic        stallreq_fr_ex_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_BYZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    ex_div_stallreq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .annul_i          (annul_i),
        .signed_i         (signed_i),
        .dividend_i       (dividend_i),
        .divisor_i        (divisor_i),
        .quot_o           (quot_o),
        .rem_o            (rem_o),
        .ready_o          (ready_o),
        .stallreq_fr_ex_o (stallreq_fr_ex_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a divide in the current (IDLE) cycle; stall must rise combinationally
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        #1;
        chk("stall_accept", {31'b0, stallreq_fr_ex_o}, 32'd1);
    endtask

    // Wait for ready with a bound; operands are scrambled once the divide is underway
    task automatic wait_ready(input string tag, input int lat,
                              input logic [31:0] eq, input logic [31:0] er);
        int cyc = 0;
        bit got = 1'b0;
        bit held = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready_o) begin
                got = 1'b1;
            end else begin
                if (!stallreq_fr_ex_o) held = 1'b0;
                if (cyc >= 2) begin
                    dividend_i = 32'hDEAD_BEEF;
                    divisor_i  = 32'h0000_0001;
                end
            end
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_stall_held"}, {31'b0, held}, 32'd1);
        chk({tag, "_stall_end"}, {31'b0, stallreq_fr_ex_o}, 32'd0);
        chk({tag, "_quot"}, quot_o, eq);
        chk({tag, "_rem"}, rem_o, er);
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input int lat);
        issue(a, b, s);
        wait_ready(tag, lat, eq, er);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_pulse"}, {31'b0, ready_o}, 32'd0);
        chk({tag, "_quot_hold"}, quot_o, eq);
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        annul_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_quot",  quot_o, 32'd0);
        chk("rst_rem",   rem_o, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd0);
        chk("rst_stall", {31'b0, stallreq_fr_ex_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
        do_div("uffff_16",32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,          33);
        do_div("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
        do_div("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33);
        do_div("smin_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33);
        do_div("u5_0",    32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          ZLAT);
        do_div("sm5_0",   32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  ZLAT);

        // Annul mid-divide: no ready, previous result retained, back in IDLE
        begin
            bit no_ready = 1'b1;
            issue(32'd100, 32'd7, 1'b0);
            repeat (10) @(negedge clk);
            annul_i = 1'b1;
            #1;
            chk("annul_stall_drop", {31'b0, stallreq_fr_ex_o}, 32'd0);
            @(negedge clk);
            annul_i = 1'b0;
            start_i = 1'b0;
            #1;
            chk("annul_idle_stall", {31'b0, stallreq_fr_ex_o}, 32'd0);
            chk("annul_quot", quot_o, 32'hFFFF_FFFF);
            chk("annul_rem",  rem_o, 32'hFFFF_FFFB);
            repeat (30) begin
                @(negedge clk);
                if (ready_o) no_ready = 1'b0;
            end
            chk("annul_no_ready", {31'b0, no_ready}, 32'd1);
        end

        // Back-to-back: second instruction presented right after the first END
        issue(32'd100, 32'd7, 1'b0);
        wait_ready("b2b_first", 33, 32'd14, 32'd2);
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        wait_ready("b2b_second", 34, 32'd3, 32'd0);
        start_i = 1'b0;
        @(negedge clk);

        // Reset mid-divide
        issue(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("midrst_quot",  quot_o, 32'd0);
        chk("midrst_rem",   rem_o, 32'd0);
        chk("midrst_ready", {31'b0, ready_o}, 32'd0);
        chk("midrst_stall", {31'b0, stallreq_fr_ex_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_div("u8_2", 32'd8, 32'd2, 1'b0, 32'd4, 32'd0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/ex_div_stallreq.md
Name: ex_div_stallreq

Overview:
- Iterative radix-2 restoring divider in the EX stage.
- Requesting side of the pipeline stall protocol: drives stallreq_fr_ex_o into the stall controller, which converts it into the PC/IF/ID/EX hold vector.
- Holds the request high for the whole divide, then drops it for exactly one cycle while the result is presented, so the pipeline advances.

Parameters:
- WIDTH, 32, operand width in bits, big-endian numbering [0:WIDTH-1].
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- start_i  input  1  EX holds a divide instruction; stays asserted while stalled.
- annul_i  input  1  flush of the EX instruction; cancels the operation.
- signed_i  input  1  1 = two's-complement divide, 0 = unsigned.
- dividend_i  input  WIDTH  dividend, sampled at accept.
- divisor_i  input  WIDTH  divisor, sampled at accept.
- quot_o  output  WIDTH  quotient.
- rem_o  output  WIDTH  remainder.
- ready_o  output  1  result valid, one-cycle pulse.
- stallreq_fr_ex_o  output  1  stall request; `STOP = 1, `NOSTOP = 0.

Behaviour:
- Reset values: state IDLE, counter 0, quot_o 0, rem_o 0, ready_o 0, stallreq_fr_ex_o 0.
- rst has priority over every other input and takes effect on the next edge from any state.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - Accept occurs when start_i=1 and annul_i=0.
  - On accept, latch operands and signed_i.
  - Divisor == 0: go to BYZERO if DIV_BYZERO_FAST_EN is defined, otherwise go to ON with the zero flag set.
  - Divisor != 0: go to ON.
- ON:
  - One restoring step per cycle, MSB first, on the absolute values of the operands.
  - Counter runs 0..WIDTH-1; at WIDTH-1, go to END.
- BYZERO: go to END after one cycle.
- END:
  - ready_o = 1 for exactly one cycle; go to IDLE unconditionally.
  - Registered quot_o and rem_o update on entry to END.
  - They hold until the next entry to END or reset.
- stallreq_fr_ex_o is combinational:
  - 1 when (IDLE & start_i & ~annul_i), or in ON or BYZERO while annul_i = 0.
  - 0 in END and in IDLE without a start.
- Normal latency: accept at cycle T, END at T+WIDTH+1; stall is asserted for cycles T..T+WIDTH.
- Back-to-back divides: the next instruction reaches EX in the cycle after END and is accepted in IDLE, with no lost cycle.
- Signed fix-up:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 gives quotient 0x80000000 and remainder 0 with no exception.
- Divide by zero, in both signed and unsigned mode: quot_o = all ones, rem_o = raw dividend, and the signed fix-up is bypassed.
- annul_i in ON or BYZERO:
  - stallreq_fr_ex_o drops in the same cycle.
  - Next state is IDLE; no END and no ready_o pulse.
  - quot_o and rem_o are unchanged.
- annul_i in END: ignored, because the result is already committed.
- Operand changes after accept are ignored.

Optional Feature:
- Macro: DIV_BYZERO_FAST_EN.
- Defined: a zero divisor goes IDLE→BYZERO→END, so ready arrives at T+2 and stall covers T..T+1.
- Undefined: BYZERO is unreachable. A zero divisor runs the full WIDTH ON iterations, ready arrives at T+WIDTH+1, and the result is identical.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'b00, BYZERO=2'b01, ON=2'b10, END=2'b11;
  - `STOP/`NOSTOP;
  - DIV_ITER = WIDTH.
- Natural sub-module: div_step. Combinational single restoring step: partial remainder plus next dividend bit minus divisor, giving the new partial remainder and the quotient bit.

Test Plan:
- Unsigned 100/7, accepted at T → stallreq high T..T+32; ready pulse at T+33; quot_o = 14, rem_o = 2.
- Signed -7/2 → quot_o = 0xFFFFFFFD, rem_o = 0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → quot_o = 0x80000000, rem_o = 0.
- 5/0 → quot_o = 0xFFFFFFFF, rem_o = 5. Ready at T+2 with DIV_BYZERO_FAST_EN, at T+33 without it.
- 100/7 accepted at T, annul_i pulsed at T+10 → stallreq low at T+10; IDLE at T+11; no ready pulse; previous quot_o/rem_o retained.
- Back-to-back 100/7 then 9/3 with start_i held → second accept in the cycle after the first END; second ready at 34 cycles after the first ready; quot_o = 3, rem_o = 0.
- rst asserted at T+5 of a divide → next cycle all outputs 0 and state IDLE; a new 8/2 then completes normally with quot_o = 4, rem_o = 0.
